// File: rtl/ssram_responder_pkg.sv
// Shared cycle-state type, burst width and chip-select decode for the SSRAM responder.
package ssram_responder_pkg;

  typedef enum logic [1:0] {
    ST_DESELECT = 2'd0,
    ST_READ     = 2'd1,
    ST_WRITE    = 2'd2
  } cycle_state_t;

  localparam int BURST_W = 2;

  function automatic logic is_selected(input logic ce1_n, input logic ce2, input logic ce3_n);
    return (~ce1_n) & ce2 & (~ce3_n);
  endfunction

endpackage

// File: rtl/ssram_resp_array.sv
// Word array for the SSRAM responder: one byte-enabled write port, one registered read port.
module ssram_resp_array
  import ssram_responder_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents survive reset; the initializer only sets the value of never-written words.
  logic [31:0] mem [0:(1 << AW) - 1] = '{default: INIT_WORD};

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register doubles as the bus output register; it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ssram_responder.sv
// Synchronous-burst SRAM responder (pipelined reads, no late write).
// Optional read/write statistics counters: define SSRAM_RESPONDER_STATS_EN.
module ssram_responder
  import ssram_responder_pkg::*;
#(
  parameter int          ARRAY_AW  = 10,
  parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [18:0] SRAM_ADDRESS,
  input  logic        SRAM_ADSC_N,
  input  logic        SRAM_ADSP_N,
  input  logic        SRAM_ADV_N,
  input  logic [3:0]  SRAM_BE_N,
  input  logic        SRAM_CE1_N,
  input  logic        SRAM_CE2,
  input  logic        SRAM_CE3_N,
  input  logic        SRAM_GW_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_OE_N,
  input  logic [31:0] iSRAM_DATA,
  output logic [31:0] oSRAM_DATA,
  output logic        oSRAM_DATA_OE
`ifdef SSRAM_RESPONDER_STATS_EN
  ,
  output logic [31:0] oRD_COUNT,
  output logic [31:0] oWR_COUNT
`endif
);

  cycle_state_t state, state_next;
  logic [18:0]  addr, addr_next;
  logic         rd_valid;
  logic         sel, adsp, adsc, wr_req, do_write;
  logic [3:0]   we_lanes;

  assign sel    = is_selected(SRAM_CE1_N, SRAM_CE2, SRAM_CE3_N);
  assign adsp   = ~SRAM_ADSP_N & ~SRAM_CE1_N;
  assign adsc   = ~SRAM_ADSC_N;
  assign wr_req = ~SRAM_GW_N | ~SRAM_WE_N;

  // Cycle decode: strobes load a new address, ADV steps the burst, otherwise hold.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    if (adsp || adsc) begin
      if (!sel) begin
        state_next = ST_DESELECT;
      end else if (adsp) begin
        addr_next  = SRAM_ADDRESS;
        state_next = ST_READ;
      end else begin
        addr_next  = SRAM_ADDRESS;
        state_next = wr_req ? ST_WRITE : ST_READ;
      end
    end else if (!SRAM_ADV_N && (state != ST_DESELECT)) begin
      addr_next  = {addr[18:BURST_W], addr[BURST_W-1:0] + BURST_W'(1'b1)};
      state_next = wr_req ? ST_WRITE : ST_READ;
    end else begin
      state_next = state;
      addr_next  = addr;
    end
  end

  assign do_write = (state_next == ST_WRITE) && wr_req;

  // GW_N overrides the byte enables and writes the whole word.
  always_comb begin
    we_lanes = 4'h0;
    if (do_write) begin
      we_lanes = SRAM_GW_N ? ~SRAM_BE_N : 4'hF;
    end else begin
      we_lanes = 4'h0;
    end
  end

  // Cycle state and burst address register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_DESELECT;
      addr  <= 19'd0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
    end
  end

  // Output-valid follows the read issued on the previous edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == ST_READ);
    end
  end

  ssram_resp_array #(
    .AW        (ARRAY_AW),
    .INIT_WORD (INIT_WORD)
  ) u_array (
    .clk   (CLK),
    .rst   (RESET),
    .we    (we_lanes),
    .waddr (addr_next[ARRAY_AW-1:0]),
    .wdata (iSRAM_DATA),
    .re    (state == ST_READ),
    .raddr (addr[ARRAY_AW-1:0]),
    .rdata (oSRAM_DATA)
  );

  assign oSRAM_DATA_OE = rd_valid & ~SRAM_OE_N;

`ifdef SSRAM_RESPONDER_STATS_EN
  logic do_read;
  assign do_read = (state_next == ST_READ);

  // Saturating access counters, one count per read or write edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      oRD_COUNT <= 32'h0000_0000;
      oWR_COUNT <= 32'h0000_0000;
    end else begin
      if (do_read && (oRD_COUNT != 32'hFFFF_FFFF)) begin
        oRD_COUNT <= oRD_COUNT + 32'd1;
      end
      if (do_write && (oWR_COUNT != 32'hFFFF_FFFF)) begin
        oWR_COUNT <= oWR_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssram_responder.sv
// Self-checking bench for ssram_responder: directed scenarios plus random traffic vs a word-level model.
module tb_ssram_responder;

  localparam int          AW   = 10;
  localparam int          NW   = 1 << AW;
  localparam logic [31:0] INIT = 32'h5A5A_0F0F;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [18:0] SRAM_ADDRESS;
  logic        SRAM_ADSC_N, SRAM_ADSP_N, SRAM_ADV_N;
  logic [3:0]  SRAM_BE_N;
  logic        SRAM_CE1_N, SRAM_CE2, SRAM_CE3_N;
  logic        SRAM_GW_N, SRAM_WE_N, SRAM_OE_N;
  logic [31:0] iSRAM_DATA;
  logic [31:0] oSRAM_DATA;
  logic        oSRAM_DATA_OE;

  int errors = 0;
  int checks = 0;

  // Reference model: word memory, current cycle kind/address, one pending read.
  logic [31:0] mmem [0:NW-1];
  int          m_kind;       // 0 deselect, 1 read, 2 write
  logic [18:0] m_addr;
  bit          m_pend;
  int          m_pend_a;
  logic [31:0] exp_data;
  bit          exp_valid;

  always #5 CLK = ~CLK;

  ssram_responder #(.ARRAY_AW(AW), .INIT_WORD(INIT)) dut (
    .CLK(CLK), .RESET(RESET), .SRAM_ADDRESS(SRAM_ADDRESS),
    .SRAM_ADSC_N(SRAM_ADSC_N), .SRAM_ADSP_N(SRAM_ADSP_N), .SRAM_ADV_N(SRAM_ADV_N),
    .SRAM_BE_N(SRAM_BE_N), .SRAM_CE1_N(SRAM_CE1_N), .SRAM_CE2(SRAM_CE2),
    .SRAM_CE3_N(SRAM_CE3_N), .SRAM_GW_N(SRAM_GW_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .iSRAM_DATA(iSRAM_DATA), .oSRAM_DATA(oSRAM_DATA),
    .oSRAM_DATA_OE(oSRAM_DATA_OE)
  );

  task automatic model_edge();
    bit sel, adsp, wr;
    int a;
    if (RESET) begin
      m_kind = 0; m_addr = 19'd0; m_pend = 0; exp_valid = 0; exp_data = 32'h0;
      return;
    end
    // A read issued last edge sees the array before this edge's write.
    exp_valid = m_pend;
    if (m_pend) exp_data = mmem[m_pend_a];
    sel  = !SRAM_CE1_N && SRAM_CE2 && !SRAM_CE3_N;
    adsp = !SRAM_ADSP_N && !SRAM_CE1_N;
    wr   = !SRAM_GW_N || !SRAM_WE_N;
    if (adsp || !SRAM_ADSC_N) begin
      if (!sel) m_kind = 0;
      else begin
        m_addr = SRAM_ADDRESS;
        m_kind = adsp ? 1 : (wr ? 2 : 1);
      end
    end else if (!SRAM_ADV_N && m_kind != 0) begin
      m_addr = (m_addr & ~19'd3) | ((m_addr + 19'd1) & 19'd3);
      m_kind = wr ? 2 : 1;
    end
    a = int'(m_addr) % NW;
    if (m_kind == 2 && wr)
      for (int i = 0; i < 4; i++)
        if (!SRAM_GW_N || !SRAM_BE_N[i]) mmem[a][8*i +: 8] = iSRAM_DATA[8*i +: 8];
    m_pend   = (m_kind == 1);
    m_pend_a = a;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    SRAM_ADSC_N = 1'b1; SRAM_ADSP_N = 1'b1; SRAM_ADV_N = 1'b1;
    SRAM_GW_N = 1'b1; SRAM_WE_N = 1'b1; SRAM_BE_N = 4'hF;
    SRAM_CE1_N = 1'b0; SRAM_CE2 = 1'b1; SRAM_CE3_N = 1'b0; SRAM_OE_N = 1'b0;
    iSRAM_DATA = 32'h0;
  endtask

  task automatic wr_word(input logic [18:0] a, input logic [31:0] d, input logic [3:0] be_n);
    idle(); SRAM_ADSC_N = 1'b0; SRAM_WE_N = 1'b0; SRAM_BE_N = be_n;
    SRAM_ADDRESS = a; iSRAM_DATA = d;
    step();
  endtask

  task automatic rd_issue(input logic [18:0] a);
    idle(); SRAM_ADSP_N = 1'b0; SRAM_ADDRESS = a;
    step();
  endtask

  task automatic test_reset();
    idle(); SRAM_ADDRESS = 19'd0; RESET = 1'b1;
    step(); step();
    checks++; if (oSRAM_DATA !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", oSRAM_DATA, 32'h0); end
    checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oSRAM_DATA_OE); end
    RESET = 1'b0;
    rd_issue(19'h003FF); idle(); step();
    checks++; if (oSRAM_DATA !== INIT) begin errors++; $display("FAIL init_word got %h want %h", oSRAM_DATA, INIT); end
  endtask

  task automatic test_write_read();
    wr_word(19'h00005, 32'hDEAD_BEEF, 4'h0);
    rd_issue(19'h00005);
    checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL s1_early_oe got %b want 0", oSRAM_DATA_OE); end
    idle(); step();
    checks++; if (oSRAM_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL s1_data got %h want %h", oSRAM_DATA, 32'hDEAD_BEEF); end
    checks++; if (oSRAM_DATA_OE !== 1'b1) begin errors++; $display("FAIL s1_oe got %b want 1", oSRAM_DATA_OE); end
    SRAM_OE_N = 1'b1; #1;
    checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL s1_oe_n_gate got %b want 0", oSRAM_DATA_OE); end
  endtask

  task automatic test_byte_lanes();
    wr_word(19'h00010, 32'h1122_3344, 4'h0);
    wr_word(19'h00010, 32'hAABB_CCDD, 4'b1010);
    rd_issue(19'h00010); idle(); step();
    checks++; if (oSRAM_DATA !== 32'h11BB_33DD) begin errors++; $display("FAIL s2_lanes got %h want %h", oSRAM_DATA, 32'h11BB_33DD); end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] order [4];
    order[0] = 32'd7; order[1] = 32'd4; order[2] = 32'd5; order[3] = 32'd6;
    for (int i = 4; i < 8; i++) wr_word(19'(i), 32'h0000_0100 + 32'(i), 4'h0);
    rd_issue(19'h00007);
    for (int i = 0; i < 4; i++) begin
      idle(); SRAM_ADV_N = (i < 3) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (oSRAM_DATA !== 32'h0000_0100 + order[i]) begin
        errors++; $display("FAIL s3_burst beat %0d got %h want %h", i, oSRAM_DATA, 32'h0000_0100 + order[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_word(19'h00030, 32'h0BAD_F00D, 4'h0);
    rd_issue(19'h00030); idle(); step();
    checks++; if (oSRAM_DATA !== 32'h0BAD_F00D) begin errors++; $display("FAIL raw_new got %h want %h", oSRAM_DATA, 32'h0BAD_F00D); end
    rd_issue(19'h00030);
    wr_word(19'h00030, 32'h600D_CAFE, 4'h0);
    checks++; if (oSRAM_DATA !== 32'h0BAD_F00D) begin errors++; $display("FAIL same_edge_old got %h want %h", oSRAM_DATA, 32'h0BAD_F00D); end
    rd_issue(19'h00030); idle(); step();
    checks++; if (oSRAM_DATA !== 32'h600D_CAFE) begin errors++; $display("FAIL after_collide got %h want %h", oSRAM_DATA, 32'h600D_CAFE); end
  endtask

  task automatic test_deselect();
    wr_word(19'h00040, 32'h0000_0001, 4'h0);
    idle(); SRAM_CE2 = 1'b0; SRAM_ADSP_N = 1'b0; SRAM_ADDRESS = 19'h00040;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL s4_oe cycle %0d got %b want 0", i, oSRAM_DATA_OE); end
      idle();
    end
    checks++; if (oSRAM_DATA !== 32'h600D_CAFE) begin errors++; $display("FAIL s4_hold got %h want %h", oSRAM_DATA, 32'h600D_CAFE); end
  endtask

  task automatic test_mid_reset();
    rd_issue(19'h00010);
    RESET = 1'b1; #1;
    checks++; if (oSRAM_DATA !== 32'h0 || oSRAM_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL s5_async got %h/%b want 0/0", oSRAM_DATA, oSRAM_DATA_OE); end
    idle(); step();
    checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL s5_in_reset got %b want 0", oSRAM_DATA_OE); end
    RESET = 1'b0; SRAM_ADV_N = 1'b0; step();
    idle(); step();
    checks++; if (oSRAM_DATA_OE !== 1'b0) begin errors++; $display("FAIL s5_no_strobe got %b want 0", oSRAM_DATA_OE); end
    rd_issue(19'h00010); idle(); step();
    checks++; if (oSRAM_DATA !== 32'h11BB_33DD || oSRAM_DATA_OE !== 1'b1) begin
      errors++; $display("FAIL s5_after got %h/%b want %h/1", oSRAM_DATA, oSRAM_DATA_OE, 32'h11BB_33DD); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      SRAM_ADSP_N = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
      SRAM_ADSC_N = ($urandom_range(0, 99) < 20) ? 1'b0 : 1'b1;
      SRAM_ADV_N  = ($urandom_range(0, 99) < 50) ? 1'b0 : 1'b1;
      SRAM_WE_N   = ($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1;
      SRAM_GW_N   = ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1;
      SRAM_BE_N   = 4'($urandom);
      SRAM_CE1_N  = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
      SRAM_CE2    = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
      SRAM_CE3_N  = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
      SRAM_OE_N   = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
      SRAM_ADDRESS = {9'($urandom), 6'd0, 4'($urandom)};
      iSRAM_DATA  = $urandom;
      RESET       = ($urandom_range(0, 199) == 0);
      step();
      checks++; if (oSRAM_DATA !== exp_data) begin errors++; $display("FAIL rand_data n=%0d got %h want %h", n, oSRAM_DATA, exp_data); end
      checks++; if (oSRAM_DATA_OE !== (exp_valid && !SRAM_OE_N)) begin
        errors++; $display("FAIL rand_oe n=%0d got %b want %b", n, oSRAM_DATA_OE, exp_valid && !SRAM_OE_N); end
    end
    RESET = 1'b0; idle(); step();
  endtask

  task automatic test_frame();
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 80; x++) begin
        idle(); SRAM_ADSC_N = 1'b0; SRAM_GW_N = 1'b0;
        SRAM_ADDRESS = 19'(y * 800 + x);
        iSRAM_DATA = 32'hA500_0000 ^ (32'(y) << 16) ^ 32'(x);
        step();
      end
    rd_issue(19'(47 * 800 + 79)); idle(); step();
    checks++; if (oSRAM_DATA !== (32'hA500_0000 ^ (32'd47 << 16) ^ 32'd79)) begin
      errors++; $display("FAIL frame_last got %h want %h", oSRAM_DATA, 32'hA500_0000 ^ (32'd47 << 16) ^ 32'd79); end
    for (int b = 0; b < NW / 4; b++) begin
      rd_issue({9'($urandom), 10'(b * 4 + 1)});
      for (int i = 0; i < 4; i++) begin
        idle(); SRAM_ADV_N = (i < 3) ? 1'b0 : 1'b1;
        step();
        checks++; if (oSRAM_DATA !== exp_data || oSRAM_DATA_OE !== exp_valid) begin
          errors++; $display("FAIL frame_read b=%0d i=%0d got %h/%b want %h/%b", b, i, oSRAM_DATA, oSRAM_DATA_OE, exp_data, exp_valid); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mmem[i] = INIT;
    m_kind = 0; m_addr = 19'd0; m_pend = 0; m_pend_a = 0; exp_data = 32'h0; exp_valid = 0;
    idle(); SRAM_ADDRESS = 19'd0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_burst_wrap();
    test_back_to_back();
    test_deselect();
    test_mid_reset();
    test_random();
    test_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
